// File: rtl/sampler_pkg.sv
// rtl/sampler_pkg.sv - shared constants and enums for the rejection sampler
// Contents: modulus constants for both modes, absorb message sizes,
// mode_e (sampling mode), state_e (controller states).
package sampler_pkg;

  localparam int unsigned Q_MLKEM     = 3329;
  localparam int unsigned Q_MLDSA     = 8380417;
  localparam int unsigned SEED_BYTES  = 32;
  localparam int unsigned NONCE_BYTES = 2;
  localparam int unsigned ABS_BYTES   = SEED_BYTES + NONCE_BYTES;

  typedef enum logic {
    MODE_MLKEM = 1'b0,
    MODE_MLDSA = 1'b1
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ABSORB  = 3'd1,
    ST_SQUEEZE = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/sampler_byte_buffer.sv
// rtl/sampler_byte_buffer.sv - byte FIFO that appends DATA_W beats and pops 3-byte groups
// Ports: clk, rst (sync active-high), clear (drop contents), push/push_data
// (append a full beat after the leftover bytes), pop (drop the 3 oldest
// bytes), head (3 oldest bytes, oldest in [7:0]), count (bytes held).
module sampler_byte_buffer #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = DATA_W / 8 + 2,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [23:0]       head,
  output logic [CNT_W-1:0]  count
);

  localparam int BPB   = DATA_W / 8;
  localparam int BUF_W = DEPTH * 8;

  logic [BUF_W-1:0] data_q;
  logic [BUF_W-1:0] shifted;
  logic [BUF_W-1:0] appended;
  logic [CNT_W-1:0] cnt_after_pop;

  // Bytes above count are always zero, so a new beat can be OR-ed in at the
  // current fill level. The caller only pushes with fewer than 3 bytes left.
  always_comb begin
    shifted       = data_q;
    cnt_after_pop = count;
    if (pop) begin
      shifted       = data_q >> 24;
      cnt_after_pop = count - CNT_W'(3);
    end
    appended = shifted;
    if (push) begin
      appended = shifted | (BUF_W'(push_data) << (8 * cnt_after_pop));
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      data_q <= '0;
      count  <= '0;
    end else begin
      data_q <= appended;
      count  <= cnt_after_pop + (push ? CNT_W'(BPB) : CNT_W'(0));
    end
  end

  assign head = data_q[23:0];

endmodule

// File: rtl/sample_ntt_stream.sv
// rtl/sample_ntt_stream.sv - XOF-driven rejection sampler for ML-KEM / ML-DSA NTT coefficients
// Ports: clk, rst (sync active-high); start_i/mode_i/seed_i/nonce_i job setup;
// xof_data/valid/last/keep_o + xof_ready_i absorb stream; xof_squeeze_*
// squeeze stream; xof_stop_o stop pulse; coeff_o/coeff_idx_o/coeff_valid_o +
// coeff_ready_i coefficient stream; busy_o, done_o status.
// Optional: SAMPLE_NTT_STREAM_STATS_EN adds reject_cnt_o (saturating reject count).
module sample_ntt_stream
  import sampler_pkg::*;
#(
  parameter int DATA_W      = 128,
  parameter int N           = 256,
  parameter int COEFF_WIDTH = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic                   mode_i,
  input  logic [255:0]           seed_i,
  input  logic [15:0]            nonce_i,
  output logic [DATA_W-1:0]      xof_data_o,
  output logic                   xof_valid_o,
  output logic                   xof_last_o,
  output logic [DATA_W/8-1:0]    xof_keep_o,
  input  logic                   xof_ready_i,
  input  logic [DATA_W-1:0]      xof_squeeze_data_i,
  input  logic                   xof_squeeze_valid_i,
  output logic                   xof_squeeze_ready_o,
  output logic                   xof_stop_o,
  output logic [COEFF_WIDTH-1:0] coeff_o,
  output logic [$clog2(N)-1:0]   coeff_idx_o,
  output logic                   coeff_valid_o,
  input  logic                   coeff_ready_i,
  output logic                   busy_o,
  output logic                   done_o
`ifdef SAMPLE_NTT_STREAM_STATS_EN
  ,
  output logic [15:0]            reject_cnt_o
`endif
);

  localparam int BPB        = DATA_W / 8;
  localparam int ABS_BEATS  = (ABS_BYTES + BPB - 1) / BPB;
  localparam int LAST_BYTES = ABS_BYTES - (ABS_BEATS - 1) * BPB;
  localparam int BEAT_W     = $clog2(ABS_BEATS + 1);
  localparam int IDX_W      = $clog2(N);
  localparam int DEPTH      = BPB + 2;
  localparam int CNT_W      = $clog2(DEPTH + 1);
  localparam int MSG_W      = ABS_BYTES * 8;
  localparam int PAD_W      = ABS_BEATS * DATA_W;

  localparam logic [BPB-1:0] ALL_KEEP  = '1;
  localparam logic [BPB-1:0] LAST_KEEP = ALL_KEEP >> (BPB - LAST_BYTES);
  localparam logic [22:0]    Q_KEM     = 23'(Q_MLKEM);
  localparam logic [22:0]    Q_DSA     = 23'(Q_MLDSA);

  state_e             state_q, state_d;
  mode_e              mode_q;
  logic [MSG_W-1:0]   msg_q;
  logic [PAD_W-1:0]   msg_pad;
  logic [BEAT_W-1:0]  beat_q;
  logic               half_q;
  logic [IDX_W-1:0]   j_q;
  logic [COEFF_WIDTH-1:0] coeff_q;
  logic [IDX_W-1:0]   idx_q;
  logic               cvalid_q;
  logic               stop_q;
  logic [15:0]        rej_q;

  logic [23:0]        head;
  logic [CNT_W-1:0]   buf_cnt;
  logic [22:0]        cand;
  logic               start_ok, abs_hs, abs_last, sq_hs, out_free;
  logic               eval, accept, last_acc, pop, buf_clear;

  assign start_ok = start_i && (state_q == ST_IDLE || state_q == ST_DONE);
  assign abs_last = (beat_q == BEAT_W'(ABS_BEATS - 1));
  assign abs_hs   = xof_valid_o && xof_ready_i;
  assign sq_hs    = xof_squeeze_valid_i && xof_squeeze_ready_o;
  assign out_free = !cvalid_q || coeff_ready_i;
  assign eval     = (state_q == ST_SQUEEZE) && (buf_cnt >= CNT_W'(3)) && out_free;

  // ML-KEM consumes one group as two 12-bit candidates (d1 then d2), so the
  // group is only popped after the second half; ML-DSA pops every candidate.
  always_comb begin
    cand = '0;
    if (mode_q == MODE_MLDSA) cand = {head[22:16], head[15:8], head[7:0]};
    else if (half_q)          cand = 23'({head[23:16], head[15:12]});
    else                      cand = 23'({head[11:8], head[7:0]});
  end

  assign accept    = cand < ((mode_q == MODE_MLDSA) ? Q_DSA : Q_KEM);
  assign last_acc  = eval && accept && (j_q == IDX_W'(N - 1));
  assign pop       = eval && ((mode_q == MODE_MLDSA) || half_q);
  assign buf_clear = start_ok || (state_q == ST_FLUSH);
  assign msg_pad   = PAD_W'(msg_q);

  sampler_byte_buffer #(.DATA_W(DATA_W)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .clear     (buf_clear),
    .push      (sq_hs),
    .push_data (xof_squeeze_data_i),
    .pop       (pop),
    .head      (head),
    .count     (buf_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (start_ok)              state_d = ST_ABSORB;
      ST_ABSORB:        if (abs_hs && abs_last)     state_d = ST_SQUEEZE;
      ST_SQUEEZE:       if (last_acc)               state_d = ST_FLUSH;
      ST_FLUSH:         if (cvalid_q && coeff_ready_i) state_d = ST_DONE;
      default:                                      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    xof_valid_o         = (state_q == ST_ABSORB);
    xof_data_o          = '0;
    xof_keep_o          = '0;
    xof_last_o          = 1'b0;
    if (state_q == ST_ABSORB) begin
      xof_data_o = msg_pad[beat_q*DATA_W +: DATA_W];
      xof_keep_o = abs_last ? LAST_KEEP : ALL_KEEP;
      xof_last_o = abs_last;
    end
    xof_squeeze_ready_o = (state_q == ST_SQUEEZE) && (buf_cnt < CNT_W'(3));
    xof_stop_o          = stop_q;
    busy_o              = (state_q == ST_ABSORB) || (state_q == ST_SQUEEZE) ||
                          (state_q == ST_FLUSH);
    done_o              = (state_q == ST_DONE);
    coeff_o             = coeff_q;
    coeff_idx_o         = idx_q;
    coeff_valid_o       = cvalid_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= MODE_MLKEM;
      msg_q    <= '0;
      beat_q   <= '0;
      half_q   <= 1'b0;
      j_q      <= '0;
      coeff_q  <= '0;
      idx_q    <= '0;
      cvalid_q <= 1'b0;
      stop_q   <= 1'b0;
      rej_q    <= '0;
    end else begin
      stop_q <= last_acc;
      if (start_ok) begin
        mode_q   <= mode_e'(mode_i);
        msg_q    <= {nonce_i, seed_i};
        beat_q   <= '0;
        half_q   <= 1'b0;
        j_q      <= '0;
        coeff_q  <= '0;
        idx_q    <= '0;
        cvalid_q <= 1'b0;
        rej_q    <= '0;
      end else begin
        if (abs_hs && !abs_last) beat_q <= beat_q + BEAT_W'(1);
        if (eval && mode_q == MODE_MLKEM) half_q <= !half_q;
        if (eval && accept) begin
          coeff_q  <= COEFF_WIDTH'(cand);
          idx_q    <= j_q;
          cvalid_q <= 1'b1;
          j_q      <= j_q + IDX_W'(1);
        end else if (cvalid_q && coeff_ready_i) begin
          cvalid_q <= 1'b0;
        end
        if (eval && !accept && rej_q != 16'hFFFF) rej_q <= rej_q + 16'd1;
      end
    end
  end

`ifdef SAMPLE_NTT_STREAM_STATS_EN
  assign reject_cnt_o = rej_q;
`else
  logic unused_rej;
  assign unused_rej = ^rej_q;
`endif

endmodule

// File: tb/tb_sample_ntt_stream.sv
// tb/tb_sample_ntt_stream.sv - self-checking bench for sample_ntt_stream against a byte-stream reference model
`timescale 1ns/1ps
module tb_sample_ntt_stream;

  localparam int DATA_W      = 128;
  localparam int N           = 256;
  localparam int COEFF_WIDTH = 23;
  localparam int BPB         = DATA_W / 8;
  localparam int IDX_W       = $clog2(N);
  localparam int MSG_BYTES   = 34;
  localparam int ABS_BEATS   = (MSG_BYTES + BPB - 1) / BPB;
  localparam int STREAM_LEN  = 2048;
  localparam int BUDGET      = 8000;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start_i;
  logic                   mode_i;
  logic [255:0]           seed_i;
  logic [15:0]            nonce_i;
  logic [DATA_W-1:0]      xof_data_o;
  logic                   xof_valid_o;
  logic                   xof_last_o;
  logic [BPB-1:0]         xof_keep_o;
  logic                   xof_ready_i;
  logic [DATA_W-1:0]      xof_squeeze_data_i;
  logic                   xof_squeeze_valid_i;
  logic                   xof_squeeze_ready_o;
  logic                   xof_stop_o;
  logic [COEFF_WIDTH-1:0] coeff_o;
  logic [IDX_W-1:0]       coeff_idx_o;
  logic                   coeff_valid_o;
  logic                   coeff_ready_i;
  logic                   busy_o;
  logic                   done_o;
`ifdef SAMPLE_NTT_STREAM_STATS_EN
  logic [15:0]            reject_cnt_o;
`endif

  sample_ntt_stream #(.DATA_W(DATA_W), .N(N), .COEFF_WIDTH(COEFF_WIDTH)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start_i             (start_i),
    .mode_i              (mode_i),
    .seed_i              (seed_i),
    .nonce_i             (nonce_i),
    .xof_data_o          (xof_data_o),
    .xof_valid_o         (xof_valid_o),
    .xof_last_o          (xof_last_o),
    .xof_keep_o          (xof_keep_o),
    .xof_ready_i         (xof_ready_i),
    .xof_squeeze_data_i  (xof_squeeze_data_i),
    .xof_squeeze_valid_i (xof_squeeze_valid_i),
    .xof_squeeze_ready_o (xof_squeeze_ready_o),
    .xof_stop_o          (xof_stop_o),
    .coeff_o             (coeff_o),
    .coeff_idx_o         (coeff_idx_o),
    .coeff_valid_o       (coeff_valid_o),
    .coeff_ready_i       (coeff_ready_i),
    .busy_o              (busy_o),
    .done_o              (done_o)
`ifdef SAMPLE_NTT_STREAM_STATS_EN
    ,
    .reject_cnt_o        (reject_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] stream [STREAM_LEN];
  int exp_q[$];
  int got_q[$];
  int exp_rej;
  int exp_rej_first;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void take(input int d, input int q);
    if (d < q) begin
      if (exp_q.size() == 0) exp_rej_first = exp_rej;
      exp_q.push_back(d);
    end else begin
      exp_rej++;
    end
  endfunction

  // Walks the squeeze byte stream in 3-byte groups and applies the sampling
  // rules directly, stopping at the N-th accepted coefficient.
  function automatic void build_model(input bit mode);
    exp_q.delete();
    exp_rej = 0;
    exp_rej_first = -1;
    for (int g = 0; g + 2 < STREAM_LEN && exp_q.size() < N; g += 3) begin
      int c0 = stream[g];
      int c1 = stream[g+1];
      int c2 = stream[g+2];
      if (!mode) begin
        take(c0 + 256 * (c1 % 16), 3329);
        if (exp_q.size() < N) take(c1 / 16 + 16 * c2, 3329);
      end else begin
        take((c0 + 256 * c1 + 65536 * c2) % 8388608, 8380417);
      end
    end
  endfunction

  task automatic fill_stream(input int kind);
    for (int i = 0; i < STREAM_LEN; i++) stream[i] = 8'($urandom);
    if (kind == 1) begin
      stream[0] = 8'hFF; stream[1] = 8'hFF; stream[2] = 8'hFF;
      stream[3] = 8'h01; stream[4] = 8'h02; stream[5] = 8'h03;
    end else if (kind == 2) begin
      stream[0] = 8'hFF; stream[1] = 8'hFF; stream[2] = 8'hFF;
      stream[3] = 8'h01; stream[4] = 8'h00; stream[5] = 8'h80;
    end else if (kind == 3) begin
      for (int i = 0; i < 32; i++) stream[i] = 8'(i);
    end
  endtask

  task automatic check_zero(input string tag);
    check(tag, {xof_data_o, xof_valid_o, xof_last_o, xof_keep_o, xof_squeeze_ready_o,
                xof_stop_o, coeff_o, coeff_idx_o, coeff_valid_o, busy_o, done_o}, '0);
`ifdef SAMPLE_NTT_STREAM_STATS_EN
    check({tag, "_rej"}, reject_cnt_o, '0);
`endif
  endtask

  // One sampling job with random handshakes. stall_at: index at which
  // coeff_ready_i is held low for 10 cycles; rst_at: abandon the job once
  // that many coefficients are out; spur_at: pulse start_i mid-job.
  task automatic run_op(input bit mode, input int stall_at, input int rst_at, input int spur_at);
    int k, ab, sp, stops, stall_left;
    bit stalled, spur_done, aborted, finished, rej_seen;
    build_model(mode);
    got_q.delete();
    for (int w = 0; w < 8; w++) seed_i[32*w +: 32] = $urandom;
    nonce_i = 16'($urandom);
    @(negedge clk);
    mode_i  = mode;
    start_i = 1'b1;
    k = 0; ab = 0; sp = 0; stops = 0; stall_left = 0;
    stalled = 0; spur_done = 0; aborted = 0; finished = 0; rej_seen = 0;
    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (xof_stop_o) stops++;
      if (done_o) begin finished = 1; break; end
      if (rst_at >= 0 && k == rst_at) begin aborted = 1; break; end
      if (spur_at >= 0 && k == spur_at && !spur_done) begin
        spur_done = 1;
        start_i = 1'b1;
      end
`ifdef SAMPLE_NTT_STREAM_STATS_EN
      if (!rej_seen && coeff_valid_o) begin
        rej_seen = 1;
        check("rej_before_first", reject_cnt_o, exp_rej_first);
      end
`endif
      xof_ready_i = ($urandom_range(0, 3) != 0);
      if (xof_valid_o && xof_ready_i) begin
        logic [DATA_W-1:0] ed, mask;
        logic [BPB-1:0] ek;
        ed = '0; mask = '0; ek = '0;
        for (int i = 0; i < BPB; i++) begin
          int kb = ab * BPB + i;
          if (kb < MSG_BYTES) begin
            ek[i] = 1'b1;
            mask[8*i +: 8] = 8'hFF;
            ed[8*i +: 8] = (kb < 32) ? seed_i[8*kb +: 8] : nonce_i[8*(kb-32) +: 8];
          end
        end
        check("absorb_keep", xof_keep_o, ek);
        check("absorb_data", xof_data_o & mask, ed);
        check("absorb_last", xof_last_o, (ab == ABS_BEATS - 1));
        ab++;
      end
      xof_squeeze_valid_i = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < BPB; i++)
        xof_squeeze_data_i[8*i +: 8] = (sp + i < STREAM_LEN) ? stream[sp + i] : 8'h00;
      if (xof_squeeze_valid_i && xof_squeeze_ready_o) sp += BPB;
      if (!stalled && stall_at >= 0 && k == stall_at && coeff_valid_o) begin
        stalled = 1;
        stall_left = 10;
      end
      if (stall_left > 0) begin
        coeff_ready_i = 1'b0;
        stall_left--;
        check("stall_hold", {coeff_valid_o, coeff_idx_o, coeff_o},
              {1'b1, IDX_W'(k), COEFF_WIDTH'(exp_q[k])});
      end else begin
        coeff_ready_i = ($urandom_range(0, 3) != 0);
      end
      if (coeff_valid_o && coeff_ready_i) begin
        if (k >= N) check("extra_coeff", 1'b1, 1'b0);
        else check("coeff", {coeff_idx_o, coeff_o}, {IDX_W'(k), COEFF_WIDTH'(exp_q[k])});
        got_q.push_back(int'(coeff_o));
        k++;
      end
    end
    xof_ready_i = 1'b0;
    xof_squeeze_valid_i = 1'b0;
    coeff_ready_i = 1'b0;
    if (!aborted) begin
      check("job_finished", finished, 1'b1);
      check("coeff_count", k, N);
      check("stop_pulses", stops, 1);
      check("busy_after", busy_o, 1'b0);
      check("sq_ready_after", xof_squeeze_ready_o, 1'b0);
      repeat (3) @(negedge clk);
      check("done_level", done_o, 1'b1);
`ifdef SAMPLE_NTT_STREAM_STATS_EN
      check("rej_total", reject_cnt_o, exp_rej);
`endif
    end
  endtask

  initial begin
    rst = 1'b1;
    start_i = 1'b0;
    mode_i = 1'b0;
    seed_i = '0;
    nonce_i = '0;
    xof_ready_i = 1'b0;
    xof_squeeze_valid_i = 1'b0;
    xof_squeeze_data_i = '0;
    coeff_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst = 1'b0;
    @(negedge clk);
    check_zero("idle_after_reset");

    fill_stream(1);
    run_op(1'b0, 50, -1, -1);
    check("kem_010203_d1", got_q[0], 513);
    check("kem_010203_d2", got_q[1], 48);

    fill_stream(2);
    run_op(1'b1, -1, -1, 30);
    check("dsa_010080", got_q[0], 1);

    fill_stream(3);
    run_op(1'b1, 120, 100, -1);
    check("group_before_edge", got_q[4], 24'h0E0D0C);
    check("group_straddle", got_q[5], 24'h11100F);
    check("abort_count", got_q.size(), 100);
    rst = 1'b1;
    @(negedge clk);
    check_zero("reset_mid_job");
    rst = 1'b0;
    @(negedge clk);

    fill_stream(0);
    run_op(1'b0, 120, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
